dcache_miss_ctrl: RTL and testbench

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

---
 rtl/dcache_miss_ctrl_if.sv | 44 ++++
 rtl/dcache_miss_ctrl.sv | 121 ++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_ctrl_if.sv
// Signal bundle between the data-cache miss controller, its load/store requesters,
// the dcache array port and the memory system. The slave modport is the controller's view.
interface dcache_miss_ctrl_if;
    // requesters
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        st_req;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        ld_grant;
    logic        st_grant;
    // dcache port
    logic [31:0] dc_addr;
    logic        dc_is_store;
    logic [1:0]  dc_st_size;
    logic [31:0] dc_in_data;
    logic        dc_hit;
    logic        fill_wr;
    logic [63:0] fill_block;
    // memory
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [3:0]  mem_trans_tag;
    logic [3:0]  mem_data_tag;
    logic [63:0] mem_data;
    // status
    logic        busy;
    logic [15:0] miss_count;

    modport master (
        output ld_req, ld_addr, st_req, st_addr, st_size, st_data,
        output dc_hit, mem_trans_tag, mem_data_tag, mem_data,
        input  ld_grant, st_grant, dc_addr, dc_is_store, dc_st_size, dc_in_data,
        input  fill_wr, fill_block, mem_cmd, mem_addr, busy, miss_count
    );

    modport slave (
        input  ld_req, ld_addr, st_req, st_addr, st_size, st_data,
        input  dc_hit, mem_trans_tag, mem_data_tag, mem_data,
        output ld_grant, st_grant, dc_addr, dc_is_store, dc_st_size, dc_in_data,
        output fill_wr, fill_block, mem_cmd, mem_addr, busy, miss_count
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Blocking data-cache miss controller: one outstanding line fill, hits from either
// requester are still served while the miss is in flight.
module dcache_miss_ctrl (
    input  logic               clock,
    input  logic               reset,
    dcache_miss_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FILL = 2'd3;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;

    logic [1:0]  state_reg, state_next;
    logic [31:0] miss_addr_reg;
    logic        owner_st_reg;
    logic [1:0]  miss_size_reg;
    logic [31:0] miss_data_reg;
    logic [3:0]  tag_reg;
    logic [63:0] block_reg;
    logic [15:0] miss_count_reg;

    logic [31:0] dc_addr_next;
    logic        dc_is_store_next;
    logic [1:0]  dc_st_size_next;
    logic [31:0] dc_in_data_next;
    logic        ld_grant_next;
    logic        st_grant_next;
    logic        fill_wr_next;
    logic        sel_valid;
    logic        miss_start;

    // Port arbitration: a pending fill always wins, then stores, then loads.
    always_comb begin
        dc_addr_next     = 32'd0;
        dc_is_store_next = 1'b0;
        dc_st_size_next  = 2'd0;
        dc_in_data_next  = 32'd0;
        ld_grant_next    = 1'b0;
        st_grant_next    = 1'b0;
        fill_wr_next     = 1'b0;
        sel_valid        = 1'b0;
        if (state_reg == S_FILL) begin
            dc_addr_next     = miss_addr_reg;
            dc_is_store_next = owner_st_reg;
            dc_st_size_next  = miss_size_reg;
            dc_in_data_next  = miss_data_reg;
            fill_wr_next     = 1'b1;
            st_grant_next    = owner_st_reg;
            ld_grant_next    = !owner_st_reg;
        end else if (bus.st_req) begin
            dc_addr_next     = bus.st_addr;
            dc_is_store_next = 1'b1;
            dc_st_size_next  = bus.st_size;
            dc_in_data_next  = bus.st_data;
            st_grant_next    = bus.dc_hit;
            sel_valid        = 1'b1;
        end else if (bus.ld_req) begin
            dc_addr_next     = bus.ld_addr;
            ld_grant_next    = bus.dc_hit;
            sel_valid        = 1'b1;
        end
    end

    assign miss_start = (state_reg == S_IDLE) && sel_valid && !bus.dc_hit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (miss_start) state_next = S_REQ;
            S_REQ:  if (bus.mem_trans_tag != 4'd0) state_next = S_WAIT;
            S_WAIT: if (tag_reg != 4'd0 && bus.mem_data_tag == tag_reg) state_next = S_FILL;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            miss_addr_reg  <= 32'd0;
            owner_st_reg   <= 1'b0;
            miss_size_reg  <= 2'd0;
            miss_data_reg  <= 32'd0;
            tag_reg        <= 4'd0;
            block_reg      <= 64'd0;
            miss_count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (miss_start) begin
                miss_addr_reg <= dc_addr_next;
                owner_st_reg  <= dc_is_store_next;
                miss_size_reg <= dc_st_size_next;
                miss_data_reg <= dc_in_data_next;
                if (miss_count_reg != 16'hFFFF)
                    miss_count_reg <= miss_count_reg + 16'd1;
            end
            if (state_reg == S_REQ && bus.mem_trans_tag != 4'd0)
                tag_reg <= bus.mem_trans_tag;
            if (state_reg == S_WAIT && state_next == S_FILL)
                block_reg <= bus.mem_data;
            // Forget the tag once the line is written so stale responses cannot match.
            if (state_reg == S_FILL)
                tag_reg <= 4'd0;
        end
    end

    assign bus.dc_addr     = dc_addr_next;
    assign bus.dc_is_store = dc_is_store_next;
    assign bus.dc_st_size  = dc_st_size_next;
    assign bus.dc_in_data  = dc_in_data_next;
    assign bus.ld_grant    = ld_grant_next;
    assign bus.st_grant    = st_grant_next;
    assign bus.fill_wr     = fill_wr_next;
    assign bus.fill_block  = (state_reg == S_FILL) ? block_reg : 64'd0;
    assign bus.mem_cmd     = (state_reg == S_REQ) ? MEM_LOAD : MEM_NONE;
    assign bus.mem_addr    = (state_reg == S_REQ) ? {miss_addr_reg[31:3], 3'b000} : 32'd0;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.miss_count  = miss_count_reg;
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: hit path, load/store misses, tag retries,
// hit-under-miss, reset mid-miss and simultaneous load/store misses.
module tb_dcache_miss_ctrl;
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd2;

    logic clock;
    logic reset;
    int   tests;
    int   failed;

    dcache_miss_ctrl_if bus ();

    dcache_miss_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_req = 0; bus.ld_addr = 0; bus.st_req = 0; bus.st_addr = 0;
        bus.st_size = 0; bus.st_data = 0; bus.dc_hit = 0;
        bus.mem_trans_tag = 0; bus.mem_data_tag = 0; bus.mem_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
        tests++; if (bus.miss_count !== 16'd0) begin failed++; $display("FAIL reset_miss_count got %0h exp 0", bus.miss_count); end
        tests++; if (bus.mem_cmd !== MEM_NONE || bus.mem_addr !== 32'd0) begin failed++; $display("FAIL reset_mem got cmd %0h addr %0h exp 0 0", bus.mem_cmd, bus.mem_addr); end
        tests++; if (bus.fill_wr !== 1'b0 || bus.ld_grant !== 1'b0 || bus.st_grant !== 1'b0 || bus.dc_addr !== 32'd0) begin
            failed++; $display("FAIL reset_outputs got fill %0h ldg %0h stg %0h dc_addr %0h exp all 0", bus.fill_wr, bus.ld_grant, bus.st_grant, bus.dc_addr); end
        $display("[TB] reset done");
    endtask

    task automatic test_ld_hit();
        bus.ld_req = 1; bus.ld_addr = 32'h100; bus.dc_hit = 1;
        #1;
        tests++; if (bus.ld_grant !== 1'b1 || bus.st_grant !== 1'b0) begin failed++; $display("FAIL ld_hit_grant got ld %0h st %0h exp 1 0", bus.ld_grant, bus.st_grant); end
        tests++; if (bus.dc_addr !== 32'h100 || bus.dc_is_store !== 1'b0) begin failed++; $display("FAIL ld_hit_dc got addr %0h st %0h exp 100 0", bus.dc_addr, bus.dc_is_store); end
        tests++; if (bus.mem_cmd !== MEM_NONE || bus.miss_count !== 16'd0) begin failed++; $display("FAIL ld_hit_mem got cmd %0h cnt %0h exp 0 0", bus.mem_cmd, bus.miss_count); end
        tick();
        clear_inputs();
        #1;
        tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL ld_hit_busy got %0h exp 0", bus.busy); end
        $display("[TB] ld hit addr 0x100");
    endtask

    task automatic test_ld_miss();
        bus.ld_req = 1; bus.ld_addr = 32'h104; bus.dc_hit = 0;
        #1;
        tests++; if (bus.ld_grant !== 1'b0) begin failed++; $display("FAIL ld_miss_nogrant got %0h exp 0", bus.ld_grant); end
        tick();
        tests++; if (bus.mem_cmd !== MEM_LOAD || bus.mem_addr !== 32'h100) begin failed++; $display("FAIL ld_miss_req got cmd %0h addr %0h exp 1 100", bus.mem_cmd, bus.mem_addr); end
        tests++; if (bus.miss_count !== 16'd1 || bus.busy !== 1'b1) begin failed++; $display("FAIL ld_miss_count got cnt %0h busy %0h exp 1 1", bus.miss_count, bus.busy); end
        bus.mem_trans_tag = 4'd3;
        tick();
        bus.mem_trans_tag = 4'd0;
        #1;
        tests++; if (bus.mem_cmd !== MEM_NONE || bus.mem_addr !== 32'd0) begin failed++; $display("FAIL ld_miss_wait_mem got cmd %0h addr %0h exp 0 0", bus.mem_cmd, bus.mem_addr); end
        tick();
        bus.mem_data_tag = 4'd3; bus.mem_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        bus.mem_data_tag = 4'd0; bus.mem_data = 64'd0;
        #1;
        tests++; if (bus.fill_wr !== 1'b1 || bus.fill_block !== 64'hDEADBEEF_CAFEF00D) begin failed++; $display("FAIL ld_miss_fill got wr %0h blk %0h exp 1 deadbeefcafef00d", bus.fill_wr, bus.fill_block); end
        tests++; if (bus.dc_addr !== 32'h104 || bus.ld_grant !== 1'b1 || bus.st_grant !== 1'b0 || bus.dc_is_store !== 1'b0) begin
            failed++; $display("FAIL ld_miss_fill_port got addr %0h ldg %0h stg %0h st %0h exp 104 1 0 0", bus.dc_addr, bus.ld_grant, bus.st_grant, bus.dc_is_store); end
        bus.ld_req = 0;
        tick();
        tests++; if (bus.busy !== 1'b0 || bus.fill_wr !== 1'b0) begin failed++; $display("FAIL ld_miss_idle got busy %0h wr %0h exp 0 0", bus.busy, bus.fill_wr); end
        $display("[TB] ld miss addr 0x104 tag 3");
    endtask

    task automatic test_st_miss_retry();
        int load_cycles;
        load_cycles = 0;
        bus.st_req = 1; bus.st_addr = 32'h208; bus.st_size = SZ_BYTE; bus.st_data = 32'hAB; bus.dc_hit = 0;
        #1;
        tests++; if (bus.st_grant !== 1'b0) begin failed++; $display("FAIL st_miss_nogrant got %0h exp 0", bus.st_grant); end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_trans_tag = (i == 2) ? 4'd5 : 4'd0;
            #1;
            if (bus.mem_cmd === MEM_LOAD && bus.mem_addr === 32'h208) load_cycles++;
            tick();
        end
        bus.mem_trans_tag = 4'd0;
        #1;
        tests++; if (load_cycles != 3) begin failed++; $display("FAIL st_miss_load_cycles got %0d exp 3", load_cycles); end
        tests++; if (bus.mem_cmd !== MEM_NONE || bus.busy !== 1'b1) begin failed++; $display("FAIL st_miss_wait got cmd %0h busy %0h exp 0 1", bus.mem_cmd, bus.busy); end
        bus.mem_data_tag = 4'd5; bus.mem_data = 64'h11223344_55667788;
        tick();
        bus.mem_data_tag = 4'd0;
        #1;
        tests++; if (bus.fill_wr !== 1'b1 || bus.dc_is_store !== 1'b1 || bus.dc_st_size !== SZ_BYTE || bus.dc_in_data !== 32'hAB || bus.dc_addr !== 32'h208) begin
            failed++; $display("FAIL st_miss_fill got wr %0h st %0h sz %0h data %0h addr %0h exp 1 1 0 ab 208", bus.fill_wr, bus.dc_is_store, bus.dc_st_size, bus.dc_in_data, bus.dc_addr); end
        tests++; if (bus.st_grant !== 1'b1 || bus.ld_grant !== 1'b0 || bus.miss_count !== 16'd2) begin
            failed++; $display("FAIL st_miss_grant got stg %0h ldg %0h cnt %0h exp 1 0 2", bus.st_grant, bus.ld_grant, bus.miss_count); end
        bus.st_req = 0;
        tick();
        $display("[TB] st miss addr 0x208 byte tag 5 after 2 rejects");
    endtask

    task automatic test_hit_under_miss();
        bus.ld_req = 1; bus.ld_addr = 32'h300; bus.dc_hit = 0;
        tick();
        bus.mem_trans_tag = 4'd2;
        tick();
        bus.mem_trans_tag = 4'd0;
        bus.st_req = 1; bus.st_addr = 32'h310; bus.st_size = SZ_WORD; bus.st_data = 32'h55; bus.dc_hit = 1;
        #1;
        tests++; if (bus.st_grant !== 1'b1 || bus.ld_grant !== 1'b0 || bus.dc_addr !== 32'h310) begin
            failed++; $display("FAIL hum_st_hit got stg %0h ldg %0h addr %0h exp 1 0 310", bus.st_grant, bus.ld_grant, bus.dc_addr); end
        tick();
        bus.st_req = 0; bus.dc_hit = 0;
        #1;
        tests++; if (bus.ld_grant !== 1'b0 || bus.st_grant !== 1'b0) begin failed++; $display("FAIL hum_ld_miss got ldg %0h stg %0h exp 0 0", bus.ld_grant, bus.st_grant); end
        tick();
        tests++; if (bus.miss_count !== 16'd3 || bus.busy !== 1'b1) begin failed++; $display("FAIL hum_count got cnt %0h busy %0h exp 3 1", bus.miss_count, bus.busy); end
        bus.mem_data_tag = 4'd7; bus.mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.mem_data_tag = 4'd0;
        #1;
        tests++; if (bus.fill_wr !== 1'b0 || bus.busy !== 1'b1) begin failed++; $display("FAIL hum_wrong_tag got wr %0h busy %0h exp 0 1", bus.fill_wr, bus.busy); end
        bus.mem_data_tag = 4'd2; bus.mem_data = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.mem_data_tag = 4'd0;
        #1;
        tests++; if (bus.fill_wr !== 1'b1 || bus.ld_grant !== 1'b1 || bus.dc_addr !== 32'h300 || bus.fill_block !== 64'h0123_4567_89AB_CDEF) begin
            failed++; $display("FAIL hum_fill got wr %0h ldg %0h addr %0h blk %0h exp 1 1 300 0123456789abcdef", bus.fill_wr, bus.ld_grant, bus.dc_addr, bus.fill_block); end
        bus.ld_req = 0;
        tick();
        $display("[TB] hit-under-miss: st hit 0x310 during ld miss 0x300 tag 2");
    endtask

    task automatic test_reset_mid_miss();
        bus.ld_req = 1; bus.ld_addr = 32'h400; bus.dc_hit = 0;
        tick();
        bus.mem_trans_tag = 4'd4;
        tick();
        bus.mem_trans_tag = 4'd0; bus.ld_req = 0; bus.ld_addr = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.mem_cmd !== MEM_NONE || bus.fill_wr !== 1'b0 || bus.dc_addr !== 32'd0 || bus.miss_count !== 16'd0) begin
            failed++; $display("FAIL rst_mid got busy %0h cmd %0h wr %0h addr %0h cnt %0h exp 0 0 0 0 0", bus.busy, bus.mem_cmd, bus.fill_wr, bus.dc_addr, bus.miss_count); end
        bus.mem_data_tag = 4'd4; bus.mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        bus.mem_data_tag = 4'd0;
        #1;
        tests++; if (bus.fill_wr !== 1'b0 || bus.busy !== 1'b0 || bus.ld_grant !== 1'b0) begin
            failed++; $display("FAIL rst_stale_tag got wr %0h busy %0h ldg %0h exp 0 0 0", bus.fill_wr, bus.busy, bus.ld_grant); end
        $display("[TB] reset in WAIT tag 4, stale data ignored");
    endtask

    task automatic test_both_miss();
        bus.st_req = 1; bus.st_addr = 32'h500; bus.st_size = SZ_WORD; bus.st_data = 32'h77;
        bus.ld_req = 1; bus.ld_addr = 32'h600; bus.dc_hit = 0;
        #1;
        tests++; if (bus.ld_grant !== 1'b0 || bus.st_grant !== 1'b0) begin failed++; $display("FAIL both_idle got ldg %0h stg %0h exp 0 0", bus.ld_grant, bus.st_grant); end
        tick();
        tests++; if (bus.mem_addr !== 32'h500 || bus.ld_grant !== 1'b0) begin failed++; $display("FAIL both_req got addr %0h ldg %0h exp 500 0", bus.mem_addr, bus.ld_grant); end
        bus.mem_trans_tag = 4'd6;
        tick();
        bus.mem_trans_tag = 4'd0;
        #1;
        tests++; if (bus.ld_grant !== 1'b0) begin failed++; $display("FAIL both_wait got ldg %0h exp 0", bus.ld_grant); end
        bus.mem_data_tag = 4'd6; bus.mem_data = 64'h5;
        tick();
        bus.mem_data_tag = 4'd0;
        #1;
        tests++; if (bus.st_grant !== 1'b1 || bus.ld_grant !== 1'b0 || bus.dc_addr !== 32'h500 || bus.dc_is_store !== 1'b1 || bus.dc_in_data !== 32'h77) begin
            failed++; $display("FAIL both_fill got stg %0h ldg %0h addr %0h st %0h data %0h exp 1 0 500 1 77", bus.st_grant, bus.ld_grant, bus.dc_addr, bus.dc_is_store, bus.dc_in_data); end
        bus.st_req = 0;
        tick();
        tests++; if (bus.ld_grant !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL both_after got ldg %0h busy %0h exp 0 0", bus.ld_grant, bus.busy); end
        tick();
        tests++; if (bus.mem_addr !== 32'h600 || bus.miss_count !== 16'd2) begin failed++; $display("FAIL both_ld_retry got addr %0h cnt %0h exp 600 2", bus.mem_addr, bus.miss_count); end
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("[TB] st 0x500 and ld 0x600 miss together, store owns first");
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_ld_hit();
        test_ld_miss();
        test_st_miss_retry();
        test_hit_under_miss();
        test_reset_mid_miss();
        test_both_miss();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
